mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Request-side controller that sits directly upstream of the 256x8 synchronous memory and drives its port (datain, addr, we; reads dataout). It accepts read/write requests over a valid/ready handshake into a small request FIFO and issues them to the memory one at a time through a state machine. Read data returns on a one-cycle response strobe. Issue counters support debug and scoreboarding.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- FIFO_DEPTH, 4, request FIFO entries (power of two, >= 2)
- RD_LAT, 1, memory read latency in cycles from address sample edge to dataout valid (>= 1)
- clk  input  1  single clock, all logic on posedge
- reset  input  1  asynchronous, active-high; clears all state
- req_valid  input  1  request present
- req_ready  output  1  FIFO can accept (= not full)
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data (ignored for reads)
- rsp_valid  output  1  one-cycle pulse, rsp_rdata valid
- rsp_rdata  output  DATA_W  read data
- mem_we  output  1  to memory we
- mem_addr  output  ADDR_W  to memory addr
- mem_datain  output  DATA_W  to memory datain
- mem_dataout  input  DATA_W  from memory dataout
- busy  output  1  FIFO non-empty or FSM not IDLE
- wr_count  output  16  writes issued, saturating
- rd_count  output  16  reads issued, saturating

## Operation
- Push on req_valid && req_ready; req_ready = !full (combinational from FIFO count). No push when full; push and pop in the same cycle are legal when not full.
- FSM states: IDLE, WRITE, READ, RD_WAIT.
- IDLE: FIFO non-empty -> pop head; register mem_addr/mem_datain/mem_we; go WRITE (we=1) or READ (we=0). Empty -> stay, mem_we=0.
- WRITE: mem_we=1 for exactly one cycle; increment wr_count; if FIFO non-empty pop next in the same edge (back-to-back issue), else IDLE.
- READ: mem_we=0, mem_addr held; increment rd_count; load wait counter with RD_LAT-1; go RD_WAIT.
- RD_WAIT: decrement counter; at zero, capture mem_dataout into rsp_rdata, pulse rsp_valid, return to IDLE. Reads are blocking: no issue while READ/RD_WAIT.
- mem_addr/mem_datain hold last value when idle; mem_we is 0 in every state except WRITE.
- Counters saturate at 16'hFFFF, never wrap.
- Requests are issued strictly in FIFO order; no reordering or forwarding.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_datain=0, rsp_valid=0, rsp_rdata=0, counters 0, busy=0; req_ready=1 once reset deasserts.
- Request accepted at edge E0 -> popped and mem port driven from E1; memory samples at E2.
- Write: mem_we high E1..E2; a queued next request drives the port from E2 (1 write/cycle sustained).
- Read, RD_LAT=1: address driven E1..E2; controller samples mem_dataout at E3; rsp_valid high E3..E4; next request popped at E4 (from IDLE). Read occupancy = RD_LAT+2 cycles.
- Reset mid-read: outstanding response discarded, no rsp_valid; queued requests lost.
- Full FIFO with pop at same edge: req_ready rises the following cycle (no full-bypass).

## Structure
- Package mem_ctrl_pkg: state enum (IDLE, WRITE, READ, RD_WAIT), request struct {we, addr, wdata}, default widths, counter width 16.
- Sub-module mem_req_fifo: synchronous FIFO of request structs with full/empty/count, async active-high reset; controller instantiates it once.

## Test plan
- Reset: assert reset mid-cycle -> all outputs 0 immediately; after release req_ready=1, busy=0.
- Write then read: write addr 0x10 data 0xA5, then read 0x10 -> mem_we pulses once with addr 0x10/datain 0xA5; rsp_valid one cycle later with rsp_rdata=0xA5; wr_count=1, rd_count=1.
- Back-to-back writes: 4 writes to 0x00..0x03 data 0x11..0x44 on consecutive cycles -> mem_we high 4 consecutive cycles, addresses in order, req_ready never drops below... FIFO never full.
- Back-pressure: hold FSM busy with reads, push 5 requests -> req_ready=0 after 4 queued; 5th accepted only after a pop; all 5 issued in order.
- Reset mid-read: issue read of 0xFF, assert reset one cycle after mem_addr=0xFF -> no rsp_valid, counters 0, FIFO empty.
- Saturation: force 65536 writes -> wr_count stays 16'hFFFF.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types, widths and helpers for the memory access controller
package mem_ctrl_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      RD_WAIT
   } ctrl_state_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } mem_req_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - synchronous request FIFO with full/empty/count
module mem_req_fifo
   import mem_ctrl_pkg::*;
#(
   parameter int W     = $bits(mem_req_t),
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = store[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - queues read/write requests and issues them one at a time to a 256x8 sync memory
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LAT     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_datain,
   input  logic [DATA_W-1:0] mem_dataout,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_count,
   output logic [CNT_W-1:0]  rd_count
);

   localparam int REQ_W  = 1 + ADDR_W + DATA_W;
   localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   ctrl_state_t        state;
   ctrl_state_t        state_n;
   req_t               push_req;
   req_t               head_req;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FCNT_W-1:0]  fifo_count;
   logic               push;
   logic               pop;
   logic               inc_wr;
   logic               inc_rd;
   logic               load_wait;
   logic               capture;
   logic [WAIT_W-1:0]  wait_cnt;

   // ready is held low while reset is asserted so nothing is pushed into a FIFO being cleared
   assign req_ready = !fifo_full && !reset;
   assign push      = req_valid && req_ready;
   assign push_req  = {req_we, req_addr, req_wdata};
   assign busy      = (fifo_count != '0) || (state != IDLE);

   mem_req_fifo #(
      .W     (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (push),
      .push_data (push_req),
      .pop       (pop),
      .head      (head_req),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      pop       = 1'b0;
      inc_wr    = 1'b0;
      inc_rd    = 1'b0;
      load_wait = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = head_req.we ? WRITE : READ;
            end
         end
         WRITE: begin
            inc_wr = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = head_req.we ? WRITE : READ;
            end else begin
               state_n = IDLE;
            end
         end
         READ: begin
            inc_rd    = 1'b1;
            load_wait = 1'b1;
            state_n   = RD_WAIT;
         end
         RD_WAIT: begin
            if (wait_cnt == '0) begin
               capture = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // the port registers load only on a pop, so address and data hold while idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_datain <= '0;
      end else if (pop) begin
         mem_we     <= head_req.we;
         mem_addr   <= head_req.addr;
         mem_datain <= head_req.wdata;
      end else begin
         mem_we     <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= capture;
         if (capture) rsp_rdata <= mem_dataout;
         if (load_wait)
            wait_cnt <= WAIT_W'(RD_LAT - 1);
         else if (state == RD_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (inc_wr) wr_count <= sat_inc(wr_count);
         if (inc_rd) rd_count <= sat_inc(rd_count);
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed table-driven bench for mem_access_ctrl with a 256x8 memory model
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_datain;
   logic [7:0]  mem_dataout;
   logic        busy;
   logic [15:0] wr_count;
   logic [15:0] rd_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [256];

   mem_access_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_datain  (mem_datain),
      .mem_dataout (mem_dataout),
      .busy        (busy),
      .wr_count    (wr_count),
      .rd_count    (rd_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // read-first synchronous memory, one cycle read latency
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_datain;
      mem_dataout <= mem[mem_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      int         exp_wr;
      int         exp_rd;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
      int t;
      t         = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && t < 50) begin
         tick();
         t++;
      end
      if (!req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles", t);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int t;
      t = 0;
      while (busy && t < 200) begin
         tick();
         t++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: still busy after %0d cycles", nm, t);
      end
   endtask

   initial begin
      logic [7:0] got [7];
      int         idx;
      int         nrsp;
      int         acc6;
      logic       rdy;
      logic       bad;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

      vecs[0] = '{1'b1, 8'h10, 8'hA5, 8'h00, 1, 0};
      vecs[1] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1, 1};
      vecs[2] = '{1'b1, 8'h20, 8'h3C, 8'h00, 2, 1};
      vecs[3] = '{1'b0, 8'h20, 8'h00, 8'h3C, 2, 2};
      vecs[4] = '{1'b0, 8'h33, 8'h00, 8'h69, 2, 3};
      vecs[5] = '{1'b1, 8'hFF, 8'h00, 8'h00, 3, 3};
      vecs[6] = '{1'b0, 8'hFF, 8'h00, 8'h00, 3, 4};
      vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h5A, 3, 5};

      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 8'h00;
      req_wdata = 8'h00;

      #12;
      check("rst_mem_we",     32'(mem_we),     32'd0);
      check("rst_mem_addr",   32'(mem_addr),   32'd0);
      check("rst_mem_datain", 32'(mem_datain), 32'd0);
      check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
      check("rst_rsp_rdata",  32'(rsp_rdata),  32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_wr_count",   32'(wr_count),   32'd0);
      check("rst_rd_count",   32'(rd_count),   32'd0);
      check("rst_req_ready",  32'(req_ready),  32'd0);
      #11;
      reset = 1'b0;
      #3;
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("post_rst_busy",  32'(busy),      32'd0);

      for (int i = 0; i < 8; i++) begin
         push(vecs[i].we, vecs[i].addr, vecs[i].wdata);
         tick();
         check($sformatf("v%0d_we", i),   32'(mem_we),   32'(vecs[i].we));
         check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
         if (vecs[i].we) begin
            check($sformatf("v%0d_datain", i), 32'(mem_datain), 32'(vecs[i].wdata));
            tick();
            check($sformatf("v%0d_we_drop", i), 32'(mem_we), 32'd0);
         end else begin
            tick();
            check($sformatf("v%0d_rsp_early", i), 32'(rsp_valid), 32'd0);
            tick();
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            tick();
            check($sformatf("v%0d_rsp_drop", i), 32'(rsp_valid), 32'd0);
         end
         check($sformatf("v%0d_wr_count", i), 32'(wr_count), 32'(vecs[i].exp_wr));
         check($sformatf("v%0d_rd_count", i), 32'(rd_count), 32'(vecs[i].exp_rd));
         check($sformatf("v%0d_busy", i),     32'(busy),     32'd0);
      end

      // back-to-back writes: one write issued per cycle
      push(1'b1, 8'h00, 8'h11);
      check("b2b_ready0", 32'(req_ready), 32'd1);
      push(1'b1, 8'h01, 8'h22);
      check("b2b_we0",   32'(mem_we),     32'd1);
      check("b2b_addr0", 32'(mem_addr),   32'h00);
      check("b2b_din0",  32'(mem_datain), 32'h11);
      check("b2b_ready1", 32'(req_ready), 32'd1);
      push(1'b1, 8'h02, 8'h33);
      check("b2b_we1",   32'(mem_we),     32'd1);
      check("b2b_addr1", 32'(mem_addr),   32'h01);
      check("b2b_din1",  32'(mem_datain), 32'h22);
      check("b2b_ready2", 32'(req_ready), 32'd1);
      push(1'b1, 8'h03, 8'h44);
      check("b2b_we2",   32'(mem_we),     32'd1);
      check("b2b_addr2", 32'(mem_addr),   32'h02);
      check("b2b_din2",  32'(mem_datain), 32'h33);
      tick();
      check("b2b_we3",   32'(mem_we),     32'd1);
      check("b2b_addr3", 32'(mem_addr),   32'h03);
      check("b2b_din3",  32'(mem_datain), 32'h44);
      tick();
      check("b2b_we_end",   32'(mem_we),   32'd0);
      check("b2b_wr_count", 32'(wr_count), 32'd7);
      wait_idle("b2b_idle");

      // back-pressure: seven reads pushed every cycle fill the FIFO while reads block issue
      idx  = 0;
      nrsp = 0;
      acc6 = -1;
      for (int c = 0; c < 60 && nrsp < 7; c++) begin
         if (rsp_valid) begin
            got[nrsp] = rsp_rdata;
            nrsp++;
         end
         rdy = req_ready;
         if (c == 5) check("bp_ready_c5", 32'(rdy), 32'd1);
         if (c == 6) check("bp_ready_c6", 32'(rdy), 32'd0);
         if (c == 7) check("bp_ready_c7", 32'(rdy), 32'd0);
         if (c == 8) check("bp_ready_c8", 32'(rdy), 32'd1);
         req_valid = (idx < 7);
         req_we    = 1'b0;
         req_addr  = 8'(8'h40 + idx);
         req_wdata = 8'h00;
         tick();
         if (req_valid && rdy) begin
            if (idx == 6) acc6 = c;
            idx++;
         end
      end
      req_valid = 1'b0;
      check("bp_accept_last_cycle", 32'(acc6), 32'd8);
      check("bp_rsp_count",         32'(nrsp), 32'd7);
      for (int i = 0; i < 7 && i < nrsp; i++)
         check($sformatf("bp_rsp%0d", i), 32'(got[i]), 32'(8'(8'h40 + i) ^ 8'h5A));
      check("bp_rd_count", 32'(rd_count), 32'd12);
      wait_idle("bp_idle");

      // reset while a read is in flight and a write is still queued
      push(1'b0, 8'hFF, 8'h00);
      push(1'b1, 8'h01, 8'h77);
      check("mrst_addr", 32'(mem_addr), 32'hFF);
      check("mrst_we",   32'(mem_we),   32'd0);
      tick();
      #3;
      reset = 1'b1;
      #1;
      check("mrst_async_addr",  32'(mem_addr),  32'd0);
      check("mrst_async_rd",    32'(rd_count),  32'd0);
      check("mrst_async_busy",  32'(busy),      32'd0);
      check("mrst_async_rsp",   32'(rsp_valid), 32'd0);
      check("mrst_async_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      tick();
      bad = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid || mem_we || busy) bad = 1'b1;
         tick();
      end
      check("mrst_no_activity", 32'(bad),      32'd0);
      check("mrst_wr_count",    32'(wr_count), 32'd0);
      check("mrst_rd_count",    32'(rd_count), 32'd0);
      check("mrst_ready",       32'(req_ready), 32'd1);

      // saturation of the write counter
      for (int i = 0; i < 65534; i++) push(1'b1, 8'(i), 8'(i));
      wait_idle("sat_idle0");
      check("sat_fffe", 32'(wr_count), 32'h0000FFFE);
      for (int i = 0; i < 3; i++) push(1'b1, 8'(i), 8'(i));
      wait_idle("sat_idle1");
      check("sat_ffff", 32'(wr_count), 32'h0000FFFF);
      check("sat_rd",   32'(rd_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
